seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter: the driving end of the serial bit-pattern detectors. On a start request it latches a PAT_W-bit pattern (default 1011), a repetition count and an inter-pattern gap, then emits the pattern MSB-first, one bit per clock, on `x`, with a `last` marker on each pattern's final bit. It acts as the stimulus source for the 1011 detectors and as a pattern generator in larger designs.

## Interface
- PAT_W, 4, pattern width in bits (≥2)
- DEF_PATTERN, 4'b1011, pattern loaded into the pattern register at reset
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- pattern_in  in  PAT_W  pattern to send, latched when start is accepted
- count  in  8  repetitions, latched at start; 0 = send nothing
- gap  in  4  zero bits between repetitions, latched at start
- x  out  1  serial data bit
- x_valid  out  1  x carries a stream bit (pattern or gap)
- last  out  1  x is the final bit of a pattern repetition
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse after the final bit

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: x=0, x_valid=0, last=0, busy=0. When start=1: latch pattern_in, count and gap. If count≠0 → SHIFT with bit index PAT_W-1 and reps=count. If count=0 → DONE.
- SHIFT: x=pattern[idx], x_valid=1, last=(idx==0). idx decrements each cycle. At idx==0, decrement reps, then:
  - if reps now 0 → DONE
  - else if gap≠0 → GAP, loaded with gap
  - else → SHIFT with idx=PAT_W-1 (back-to-back)
- GAP: x=0, x_valid=1, last=0. Runs for exactly `gap` cycles, then → SHIFT with idx=PAT_W-1.
- DONE: done=1, x_valid=0, for one cycle, then → IDLE.
- start outside IDLE is ignored. pattern_in/count/gap changes after acceptance have no effect.
- Counters: idx is $clog2(PAT_W) bits, reps is 8 bits, gap counter is 4 bits. No counter wraps: every transition fires at zero before any decrement below zero.
- Reset (async, any state, including mid-pattern): state=IDLE. All outputs are 0. Counters clear. Pattern register = DEF_PATTERN. Transmission does not resume after release.

## Timing
- Outputs are registered (Moore): they are a function of the registered state and datapath only.
- start accepted at edge k → first bit on x during cycle k+1.
- For count N≥1 and gap G: x_valid is high for N·PAT_W + (N−1)·G consecutive cycles. done follows in the next cycle. Back-to-back start is possible in the cycle after done.
- count=0: done is high in cycle k+1, and x_valid stays 0.
- last is high in the cycle a downstream Moore detector samples the final pattern bit. Its matching output rises one cycle later.

## Structure
- Shared package `seq_pkg`: state typedef (IDLE, SHIFT, GAP, DONE), constant `SEQ_1011 = 4'b1011`. This constant is also used by the detectors.
- Single module, no sub-module. The datapath is a shift/index register plus two down-counters.

## Test plan
- Reset: hold rst_n=0, toggle start → x, x_valid, last, busy and done stay 0. Release rst_n → no activity until start.
- pattern 1011, count=1, gap=0, start at cycle 0 → x=1,0,1,1 in cycles 1–4. last high in cycle 4 only. done in cycle 5. busy in cycles 1–5.
- pattern 1011, count=3, gap=2 → x stream 1011 00 1011 00 1011 (cycles 1–16). last high in cycles 4, 10 and 16. done in cycle 17. A 1011 detector fires 3 times.
- pattern 1011, count=2, gap=0, extra start pulses in cycles 2 and 6 → stream 10111011 (cycles 1–8). Extra starts ignored. done in cycle 9.
- count=0, start at cycle 0 → done in cycle 1 and busy in cycle 1 only. x_valid never high.
- count=5 started, rst_n pulsed low mid-cycle 3 → all outputs 0 immediately, and the stream does not resume. A new start with pattern 1101, count=1 after release → x=1,1,0,1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the 1011 detectors.
package seq_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Canonical pattern shared by the transmitter default and the detectors
    localparam logic [3:0] SEQ_1011 = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: on start, latches a pattern, a repetition count
// and a gap length, then sends the pattern MSB-first one bit per clock with a
// run of zero bits between repetitions. All outputs come straight from flops.
//
// Handshake: start is a request sampled only while idle; acceptance is
// implied by busy rising in the next cycle. There is no backpressure: the
// receiver must take x on every cycle where x_valid is high.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(SEQ_1011)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [7:0]       count,
    input  logic [3:0]       gap,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy,
    output logic             done,
    output state_t           state_dbg
);

    localparam int               IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

    state_t             r_state,   w_state;
    logic [PAT_W-1:0]   r_pattern, w_pattern;
    logic [IDX_W-1:0]   r_idx,     w_idx;
    logic [7:0]         r_reps,    w_reps;
    logic [3:0]         r_gap_len, w_gap_len;
    logic [3:0]         r_gap_cnt, w_gap_cnt;

    logic               r_x, r_x_valid, r_last, r_busy, r_done;

    // Next-state and datapath update; counters only step while non-zero
    always_comb begin
        w_state   = r_state;
        w_pattern = r_pattern;
        w_idx     = r_idx;
        w_reps    = r_reps;
        w_gap_len = r_gap_len;
        w_gap_cnt = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_pattern = pattern_in;
                    w_reps    = count;
                    w_gap_len = gap;
                    w_idx     = IDX_MAX;
                    w_gap_cnt = 4'd0;
                    w_state   = (count != 8'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (r_idx == '0) begin
                    // reps is at least 1 in SHIFT, so this never wraps
                    w_reps = r_reps - 8'd1;
                    if (r_reps == 8'd1) begin
                        w_state = DONE;
                    end else if (r_gap_len != 4'd0) begin
                        // Counter holds remaining gap cycles minus one
                        w_state   = GAP;
                        w_gap_cnt = r_gap_len - 4'd1;
                    end else begin
                        w_idx = IDX_MAX;
                    end
                end else begin
                    w_idx = r_idx - IDX_W'(1);
                end
            end
            GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state = SHIFT;
                    w_idx   = IDX_MAX;
                end else begin
                    w_gap_cnt = r_gap_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pattern <= DEF_PATTERN;
            r_idx     <= '0;
            r_reps    <= 8'd0;
            r_gap_len <= 4'd0;
            r_gap_cnt <= 4'd0;
        end else begin
            r_state   <= w_state;
            r_pattern <= w_pattern;
            r_idx     <= w_idx;
            r_reps    <= w_reps;
            r_gap_len <= w_gap_len;
            r_gap_cnt <= w_gap_cnt;
        end
    end

    // Output flops decoded from the next state so they line up with r_state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_x       <= (w_state == SHIFT) && w_pattern[w_idx];
            r_x_valid <= (w_state == SHIFT) || (w_state == GAP);
            r_last    <= (w_state == SHIFT) && (w_idx == '0);
            r_busy    <= (w_state != IDLE);
            r_done    <= (w_state == DONE);
        end
    end

    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign last      = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed testbench for seq_pattern_tx. Cycle 1 is the first cycle after the
// edge that accepts start; outputs are sampled on the falling edge.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] pattern_in;
  logic [7:0] count;
  logic [3:0] gap;
  logic       x, x_valid, last, busy, done;
  state_t     state_dbg;

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(4), .DEF_PATTERN(4'b1011)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pattern_in (pattern_in),
    .count      (count),
    .gap        (gap),
    .x          (x),
    .x_valid    (x_valid),
    .last       (last),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " x"},       32'(x),       32'd0);
    check({tag, " x_valid"}, 32'(x_valid), 32'd0);
    check({tag, " last"},    32'(last),    32'd0);
    check({tag, " busy"},    32'(busy),    32'd0);
    check({tag, " done"},    32'(done),    32'd0);
  endtask

  // ---------------- driver ----------------
  // Expected vectors: bit c holds the value for cycle c. A reference 1011
  // detector watches the valid stream and its hit count is checked too.
  task automatic run_case(input string tag, input logic [3:0] pat, input logic [7:0] cnt,
                          input logic [3:0] gp, input int ncyc,
                          input logic [31:0] ex, input logic [31:0] ev, input logic [31:0] el,
                          input logic [31:0] eb, input logic [31:0] ed,
                          input int s1, input int s2, input int exp_hits);
    logic [3:0] win;
    int         hits;
    win  = 4'd0;
    hits = 0;
    @(negedge clk);
    pattern_in = pat;
    count      = cnt;
    gap        = gp;
    start      = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d x", tag, c),       32'(x),       32'(ex[c]));
      check($sformatf("%s c%0d x_valid", tag, c), 32'(x_valid), 32'(ev[c]));
      check($sformatf("%s c%0d last", tag, c),    32'(last),    32'(el[c]));
      check($sformatf("%s c%0d busy", tag, c),    32'(busy),    32'(eb[c]));
      check($sformatf("%s c%0d done", tag, c),    32'(done),    32'(ed[c]));
      if (x_valid) begin
        win = {win[2:0], x};
        if (win == 4'b1011) hits++;
      end
      // Scramble inputs after acceptance; only latched values may matter
      pattern_in = ~pat;
      count      = cnt + 8'd7;
      gap        = gp + 4'd3;
      start      = ((c + 1) == s1) || ((c + 1) == s2);
    end
    start = 1'b0;
    check({tag, " detector hits"}, 32'(hits), 32'(exp_hits));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    pattern_in = 4'b1011;
    count      = 8'd5;
    gap        = 4'd1;

    // Reset held: start toggling must not wake anything up
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_quiet($sformatf("rst_hold%0d", i));
      check($sformatf("rst_hold%0d state", i), 32'(state_dbg), 32'(IDLE));
      start = ~start;
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet($sformatf("post_rst%0d", i));
    end

    // count=1 gap=0: 1011 in cycles 1-4, done cycle 5
    run_case("c1g0", 4'b1011, 8'd1, 4'd0, 6,
             32'b11010, 32'b11110, 32'b10000, 32'b111110, 32'b100000, 0, 0, 1);

    // count=3 gap=2: 1011 00 1011 00 1011, done cycle 17
    run_case("c3g2", 4'b1011, 8'd3, 4'd2, 19,
             32'b1_1010_0110_1001_1010, 32'h1FFFE, 32'h10410, 32'h3FFFE, 32'h20000, 0, 0, 3);

    // count=2 gap=0 with extra start pulses mid-stream
    run_case("c2g0", 4'b1011, 8'd2, 4'd0, 11,
             32'b1_1011_1010, 32'h1FE, 32'h110, 32'h3FE, 32'h200, 2, 6, 2);

    // count=0: only a done pulse in cycle 1
    run_case("c0", 4'b1011, 8'd0, 4'd3, 3,
             32'h0, 32'h0, 32'h0, 32'h2, 32'h2, 0, 0, 0);

    // gap=1 boundary with a different pattern: 0110 0 0110
    run_case("c2g1", 4'b0110, 8'd2, 4'd1, 11,
             32'h18C, 32'h3FE, 32'h210, 32'h7FE, 32'h400, 0, 0, 0);

    // Asynchronous reset mid-transmission
    @(negedge clk);
    pattern_in = 4'b1011;
    count      = 8'd5;
    gap        = 4'd0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrst c1 x", 32'(x), 32'd1);
    @(negedge clk);
    check("midrst c2 x", 32'(x), 32'd0);
    @(negedge clk);
    check("midrst c3 x", 32'(x), 32'd1);
    check("midrst c3 busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_quiet("midrst asserted");
    check("midrst state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_quiet($sformatf("midrst idle%0d", i));
    end

    // Fresh transfer after reset release: 1101, count=1
    run_case("p1101", 4'b1101, 8'd1, 4'd0, 6,
             32'b10110, 32'b11110, 32'b10000, 32'b111110, 32'b100000, 0, 0, 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
